// File: rtl/mbldcm_pkg.sv
// Shared types and helpers for the BLDC commutation sequencer.
// Local-phase arithmetic and raw high/low side decode live here so they can be reused.
package mbldcm_pkg;

  typedef struct packed {
    logic high;
    logic low;
  } raw_drive_t;

  // Adds stages before subtracting so the offset never underflows.
  function automatic int unsigned local_phase(input int unsigned phase,
                                              input int unsigned offset,
                                              input int unsigned stages);
    return (phase + stages - offset) % stages;
  endfunction

  function automatic raw_drive_t decode_raw(input int unsigned lph,
                                            input int unsigned on_stages,
                                            input int unsigned stages);
    raw_drive_t r;
    r.high = (lph < on_stages);
    r.low  = (lph >= stages / 2) && (lph < stages / 2 + on_stages);
    return r;
  endfunction

endpackage

// File: rtl/mbldcm_deadtime.sv
// Single-bit dead-time inserter: delays rising edges by iDeadTime+1 cycles,
// passes falling edges after one cycle.
module mbldcm_deadtime #(
  parameter int unsigned pDeadW = 4
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iClr,
  input  logic              iRaw,
  input  logic [pDeadW-1:0] iDeadTime,
  output logic              oOut
);

  logic [pDeadW-1:0] cnt_q, cnt_d;
  logic              out_q, out_d;

  always_comb begin
    cnt_d = cnt_q;
    out_d = 1'b0;
    if (iClr || !iRaw) begin
      cnt_d = '0;
    end else if (cnt_q == iDeadTime) begin
      out_d = 1'b1;
    end else begin
      cnt_d = cnt_q + pDeadW'(1);
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign oOut = out_q;

endmodule

// File: rtl/mbldcm_phase_sequencer.sv
// Multi-channel BLDC commutation sequencer: prescaled phase counter plus
// per-channel high/low drive decode with dead-time insertion.
module mbldcm_phase_sequencer
  import mbldcm_pkg::*;
#(
  parameter int unsigned pChannels = 3,
  parameter int unsigned pStages   = 12,
  parameter int unsigned pOnStages = 2,
  parameter int unsigned pPeriodW  = 16,
  parameter int unsigned pDeadW    = 4,
  localparam int unsigned pPhaseW  = $clog2(pStages)
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic                 iEnable,
  input  logic                 iDir,
  input  logic [pPeriodW-1:0]  iPeriod,
  input  logic [pDeadW-1:0]    iDeadTime,
  input  logic                 iPhaseLoad,
  input  logic [pPhaseW-1:0]   iPhaseInit,
  output logic [pPhaseW-1:0]   oPhase,
  output logic                 oStep,
  output logic [pChannels-1:0] oPulseH,
  output logic [pChannels-1:0] oPulseL
);

  localparam logic [pPhaseW-1:0] LastPhase = pPhaseW'(pStages - 1);

  logic [pPeriodW-1:0] pre_q, pre_d;
  logic [pPhaseW-1:0]  phase_q, phase_d;
  logic                step_q, step_d;

  always_comb begin
    pre_d   = pre_q;
    phase_d = phase_q;
    step_d  = 1'b0;
    if (iPhaseLoad) begin
      phase_d = (32'(iPhaseInit) >= pStages) ? '0 : iPhaseInit;
      pre_d   = '0;
    end else if (!iEnable || (iPeriod == '0)) begin
      pre_d = '0;
    end else if (pre_q >= iPeriod - pPeriodW'(1)) begin
      // >= so that shrinking iPeriod below the running count steps immediately
      pre_d  = '0;
      step_d = 1'b1;
      if (iDir) begin
        phase_d = (phase_q == '0) ? LastPhase : phase_q - pPhaseW'(1);
      end else begin
        phase_d = (phase_q == LastPhase) ? '0 : phase_q + pPhaseW'(1);
      end
    end else begin
      pre_d = pre_q + pPeriodW'(1);
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      pre_q   <= '0;
      phase_q <= '0;
      step_q  <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      phase_q <= phase_d;
      step_q  <= step_d;
    end
  end

  assign oPhase = phase_q;
  assign oStep  = step_q;

  for (genvar k = 0; k < pChannels; k++) begin : g_ch
    localparam int unsigned Offset = k * pStages / pChannels;

    raw_drive_t raw;

    always_comb begin
      raw = decode_raw(local_phase(32'(phase_q), Offset, pStages), pOnStages, pStages);
    end

    mbldcm_deadtime #(
      .pDeadW(pDeadW)
    ) u_dt_h (
      .iClk     (iClk),
      .iRst_n   (iRst_n),
      .iClr     (~iEnable),
      .iRaw     (raw.high),
      .iDeadTime(iDeadTime),
      .oOut     (oPulseH[k])
    );

    mbldcm_deadtime #(
      .pDeadW(pDeadW)
    ) u_dt_l (
      .iClk     (iClk),
      .iRst_n   (iRst_n),
      .iClr     (~iEnable),
      .iRaw     (raw.low),
      .iDeadTime(iDeadTime),
      .oOut     (oPulseL[k])
    );
  end

endmodule

// File: doc/mbldcm_phase_sequencer.md
# mbldcm_phase_sequencer

Parametrised multi-channel commutation sequencer for the BLDC motor driver. Owns a free-running electrical-phase counter advanced by a programmable step prescaler, forward or reverse. Derives per-channel high-side/low-side drive pulses from per-channel phase offsets and inserts programmable dead time before each rising edge. Sits between the motor-control register block and the gate-driver pins.

## Interface
- pChannels, 3, number of motor phases/channels; pStages must be divisible by pChannels.
- pStages, 12, electrical phase stages per revolution; even, 4..256.
- pOnStages, 2, stages per pulse; 1..pStages/2.
- pPeriodW, 16, prescaler width.
- pDeadW, 4, dead-time counter width.
- Derived localparam pPhaseW = $clog2(pStages).
- iClk  in  1  clock.
- iRst_n  in  1  reset, asynchronous, active-low.
- iEnable  in  1  run enable.
- iDir  in  1  0 = phase increments, 1 = phase decrements.
- iPeriod  in  pPeriodW  clock cycles per phase step; 0 = hold.
- iDeadTime  in  pDeadW  rising-edge delay in cycles.
- iPhaseLoad  in  1  load strobe.
- iPhaseInit  in  pPhaseW  value loaded on iPhaseLoad.
- oPhase  out  pPhaseW  current phase, 0..pStages-1.
- oStep  out  1  one-cycle strobe, coincident with oPhase update.
- oPulseH  out  pChannels  high-side drive, bit k = channel k.
- oPulseL  out  pChannels  low-side drive.

## Operation
- Prescaler: rPre counts up each enabled cycle. When rPre >= iPeriod-1 (terminal), rPre <= 0, the phase steps, and oStep <= 1. Otherwise oStep <= 0.
- Comparison `>=` means lowering iPeriod below the current count steps on the next edge.
- iPeriod == 0: rPre held at 0, no steps.
- Phase step: forward (pStages-1)->0, reverse 0->(pStages-1).
- Priority, highest first:
  - reset;
  - iPhaseLoad: oPhase <= iPhaseInit, or 0 if iPhaseInit >= pStages; rPre <= 0; oStep <= 0. Applies whether or not iEnable is high.
  - iEnable low: rPre <= 0, phase held, oStep <= 0.
  - terminal step.
- Channel k local phase L = (oPhase - k*pStages/pChannels) mod pStages, computed without underflow (add pStages before subtracting).
- Raw high side = L in [0, pOnStages). Raw low side = L in [pStages/2, pStages/2+pOnStages). The two are mutually exclusive by construction.
- Dead time, one independent counter per output bit:
  - raw 0 or iEnable 0: cnt <= 0, out <= 0;
  - else if cnt == iDeadTime: out <= 1 (cnt holds);
  - else cnt <= cnt+1, out <= 0.
- Rising edge is delayed, falling edge is not, so H and L of one channel are never high together.
- A raw pulse shorter than iDeadTime+1 cycles produces no output pulse.
- Changing iDeadTime mid-pulse takes effect on the next compare.

## Timing
- Reset values: oPhase=0, rPre=0, oStep=0, oPulseH=0, oPulseL=0, all dead-time counters 0.
- oPhase and oStep update on the same edge.
- Output latency from oPhase change: rising edge iDeadTime+1 cycles; falling edge 1 cycle.
- iEnable deassertion: all pulses low on the next edge.
- iEnable reassertion: the first step occurs iPeriod cycles later.
- Asynchronous reset mid-pulse clears outputs immediately, without a clock.
- Step rate: one step per iPeriod cycles; iPeriod == 1 steps every cycle.

## Structure
- Package mbldcm_pkg holds:
  - the function computing local phase from (phase, offset, stages);
  - the function decoding raw H/L from (local phase, pOnStages, pStages).
- Sub-module mbldcm_deadtime (one output bit: iClk, iRst_n, iClr, iRaw, iDeadTime, oOut), instantiated 2*pChannels times by generate loop.

## Test plan
All scenarios use pChannels=3, pStages=12, pOnStages=2.
- Reset: hold iRst_n=0 with iEnable=1 and iPeriod=4. Every output is 0. After release, the first oStep comes on cycle 4 and oPhase becomes 1.
- Forward sequence, iPeriod=4, iDeadTime=0:
  - oPhase steps every 4 cycles and wraps 11->0;
  - ch0 H high during phases 0,1; ch0 L during 6,7; ch1 H during 4,5; ch2 L during 2,3 (local 6,7); each delayed 1 cycle.
- Reverse: load 0, iDir=1, iPeriod=1. oPhase sequence is 0,11,10,…, and oStep is high every cycle.
- Dead time: iPeriod=4, iDeadTime=3.
  - ch0 H rises 4 cycles after oPhase enters 0 and falls 1 cycle after it leaves 1.
  - With iPeriod=2 and iDeadTime=5 (raw 4 cycles), H never rises.
  - H and L are never both high.
- Load priority: iPhaseLoad=1 with iPhaseInit=5 on a terminal cycle gives oPhase=5, oStep=0, rPre=0. iPhaseInit=13 loads 0.
- Mid-operation: while ch0 H is high, drop iEnable. Pulses go 0 on the next edge and the phase is held. Then assert iRst_n=0 asynchronously between edges: all outputs clear immediately.
